// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file: default geometry and
// MIPS architectural register indices.
package regfile_mp_pkg;

  localparam int DEF_DW = 32;
  localparam int DEF_AW = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_T0   = 8;
  localparam int REG_T1   = 9;
  localparam int REG_T2   = 10;
  localparam int REG_T3   = 11;
  localparam int REG_T4   = 12;
  localparam int REG_T5   = 13;
  localparam int REG_T6   = 14;
  localparam int REG_T7   = 15;
  localparam int REG_S0   = 16;
  localparam int REG_S1   = 17;
  localparam int REG_S2   = 18;
  localparam int REG_S3   = 19;
  localparam int REG_S4   = 20;
  localparam int REG_S5   = 21;
  localparam int REG_S6   = 22;
  localparam int REG_S7   = 23;
  localparam int REG_T8   = 24;
  localparam int REG_T9   = 25;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for hazard detection. An issue marks a register
// pending; a writeback to it clears the bit. Issue wins over writeback on the
// same register because the newly issued producer supersedes the old one.
import regfile_mp_pkg::*;

module regfile_scoreboard #(
  parameter int AW       = DEF_AW,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_en,
  input  logic [AW-1:0]        issue_addr,
  input  logic                 wen0,
  input  logic [AW-1:0]        waddr0,
  input  logic                 wen1,
  input  logic [AW-1:0]        waddr1,
  input  logic [NUM_RD*AW-1:0] raddr,
  output logic [NUM_RD-1:0]    rbusy,
  output logic [(2**AW)-1:0]   busy_vec
);

  localparam int DEPTH = 2**AW;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  // True when either write port retires into the given register this cycle.
  function automatic logic wr_hit(input logic [AW-1:0] a,
                                  input logic w0, input logic [AW-1:0] a0,
                                  input logic w1, input logic [AW-1:0] a1);
    return (w0 && (a0 == a)) || (w1 && (a1 == a));
  endfunction

  // Next busy state: issue sets, writeback clears, otherwise hold.
  always_comb begin
    busy_nxt = busy;
    for (int a = 0; a < DEPTH; a++) begin
      if (issue_en && (issue_addr == AW'(a)))
        busy_nxt[a] = 1'b1;
      else if (wr_hit(AW'(a), wen0, waddr0, wen1, waddr1))
        busy_nxt[a] = 1'b0;
    end
    if (ZERO_REG != 0)
      busy_nxt[0] = 1'b0;
  end

  // Busy bit register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  // A consumer whose producer writes back this cycle sees it as ready.
  always_comb begin
    rbusy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rbusy[i] = busy[raddr[i*AW +: AW]] &&
                 !wr_hit(raddr[i*AW +: AW], wen0, waddr0, wen1, waddr1);
    end
  end

  assign busy_vec = busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two posedge write ports (port 1 is the younger
// instruction and wins collisions), NUM_RD combinational read ports with
// same-cycle write-through bypass, optional hardwired zero register, busy
// scoreboard and an unbypassed debug read port.
import regfile_mp_pkg::*;

module regfile_mp #(
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] raddr,
  output logic [NUM_RD*DW-1:0] rdata,
  output logic [NUM_RD-1:0]    rbusy,
  input  logic                 wen0,
  input  logic [AW-1:0]        waddr0,
  input  logic [DW-1:0]        wdata0,
  input  logic                 wen1,
  input  logic [AW-1:0]        waddr1,
  input  logic [DW-1:0]        wdata1,
  input  logic                 issue_en,
  input  logic [AW-1:0]        issue_addr,
  input  logic [AW-1:0]        dbg_addr,
  output logic [DW-1:0]        dbg_data,
  output logic [(2**AW)-1:0]   busy_vec
);

  localparam int DEPTH = 2**AW;

  logic [DW-1:0] mem [DEPTH];
  logic          w0_ok;
  logic          w1_ok;

  // Writes to the hardwired zero register are dropped.
  assign w0_ok = wen0 && !((ZERO_REG != 0) && (waddr0 == '0));
  assign w1_ok = wen1 && !((ZERO_REG != 0) && (waddr1 == '0));

  // Storage commit; port 1 is applied last so the younger write wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++)
        mem[k] <= '0;
    end else begin
      if (w0_ok)
        mem[waddr0] <= wdata0;
      if (w1_ok)
        mem[waddr1] <= wdata1;
    end
  end

  // Read ports: zero register, then port 1 bypass, port 0 bypass, storage.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if ((ZERO_REG != 0) && (raddr[i*AW +: AW] == '0))
        rdata[i*DW +: DW] = '0;
      else if (wen1 && (waddr1 == raddr[i*AW +: AW]))
        rdata[i*DW +: DW] = wdata1;
      else if (wen0 && (waddr0 == raddr[i*AW +: AW]))
        rdata[i*DW +: DW] = wdata0;
      else
        rdata[i*DW +: DW] = mem[raddr[i*AW +: AW]];
    end
  end

  // Debug port shows committed state only.
  always_comb begin
    dbg_data = mem[dbg_addr];
    if ((ZERO_REG != 0) && (dbg_addr == '0))
      dbg_data = '0;
  end

  regfile_scoreboard #(
    .AW       (AW),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wen0       (wen0),
    .waddr0     (waddr0),
    .wen1       (wen1),
    .waddr1     (waddr1),
    .raddr      (raddr),
    .rbusy      (rbusy),
    .busy_vec   (busy_vec)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios plus random traffic checked
// against an array-based reference model of the register file.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic            wen0, wen1, issue_en;
  logic [AW-1:0]   waddr0, waddr1, issue_addr, dbg_addr;
  logic [DW-1:0]   wdata0, wdata1, dbg_data;
  logic [DEPTH-1:0] busy_vec;

  regfile_mp #(.DW(DW), .AW(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy_vec(busy_vec)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [DEPTH];
  logic          ref_busy [DEPTH];
  logic [DW-1:0] exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wen1 && waddr1 == a) return wdata1;
    if (wen0 && waddr0 == a) return wdata0;
    return ref_mem[a];
  endfunction

  function automatic logic model_rbusy(input logic [AW-1:0] a);
    logic written;
    written = (wen0 && waddr0 == a) || (wen1 && waddr1 == a);
    return ref_busy[a] && !written;
  endfunction

  function automatic logic [DEPTH-1:0] model_busy_vec();
    logic [DEPTH-1:0] v;
    for (int a = 0; a < DEPTH; a++) v[a] = ref_busy[a];
    return v;
  endfunction

  // Clock edge as seen by the model.
  task automatic model_commit();
    if (rst) begin
      for (int a = 0; a < DEPTH; a++) begin
        ref_mem[a] = '0;
        ref_busy[a] = 1'b0;
      end
    end else begin
      for (int a = 1; a < DEPTH; a++) begin
        if (issue_en && issue_addr == a)
          ref_busy[a] = 1'b1;
        else if ((wen0 && waddr0 == a) || (wen1 && waddr1 == a))
          ref_busy[a] = 1'b0;
      end
      if (wen0 && waddr0 != 0) ref_mem[waddr0] = wdata0;
      if (wen1 && waddr1 != 0) ref_mem[waddr1] = wdata1;
    end
  endtask

  // Scoreboard: queue expectations for all outputs, then pop and compare.
  task automatic check_outputs();
    exp_q.push_back(model_read(raddr[AW-1:0]));
    exp_q.push_back(model_read(raddr[2*AW-1:AW]));
    exp_q.push_back({30'd0, model_rbusy(raddr[2*AW-1:AW]), model_rbusy(raddr[AW-1:0])});
    exp_q.push_back(dbg_addr == 0 ? '0 : ref_mem[dbg_addr]);
    exp_q.push_back(model_busy_vec());
    check("rdata0", rdata[DW-1:0], exp_q.pop_front());
    check("rdata1", rdata[2*DW-1:DW], exp_q.pop_front());
    check("rbusy", {30'd0, rbusy}, exp_q.pop_front());
    check("dbg_data", dbg_data, exp_q.pop_front());
    check("busy_vec", busy_vec, exp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic drive(input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic ie, input logic [AW-1:0] ia,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                       input logic [AW-1:0] da);
    wen0 = w0; waddr0 = a0; wdata0 = d0;
    wen1 = w1; waddr1 = a1; wdata1 = d1;
    issue_en = ie; issue_addr = ia;
    raddr = {r1, r0}; dbg_addr = da;
    #1;
    check_outputs();
  endtask

  task automatic drive_idle(input logic [AW-1:0] r0, input logic [AW-1:0] da);
    drive(0, 0, 0, 0, 0, 0, 0, 0, r0, 0, da);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
    return AW'($urandom_range(0, 5) + 8);
  endfunction

  task automatic drive_random();
    drive($urandom_range(0, 1) == 1, rand_addr(), $urandom,
          $urandom_range(0, 1) == 1, rand_addr(), $urandom,
          $urandom_range(0, 2) == 0, rand_addr(),
          rand_addr(), rand_addr(), rand_addr());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      ref_mem[a] = '0;
      ref_busy[a] = 1'b0;
    end
    rst = 1'b1;
    wen0 = 0; waddr0 = 0; wdata0 = 0;
    wen1 = 0; waddr1 = 0; wdata1 = 0;
    issue_en = 0; issue_addr = 0; raddr = 0; dbg_addr = 0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // 1: random activity, then reset clears everything
    for (int c = 0; c < 20; c++) begin drive_random(); tick(); end
    rst = 1'b1;
    drive_idle(0, 0); tick();
    drive_idle(0, 0); tick();
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      drive_idle(AW'(a), AW'(a));
      check("rst_dbg", dbg_data, 32'd0);
    end
    check("rst_busy_vec", busy_vec, 32'd0);
    check("rst_rbusy", {30'd0, rbusy}, 32'd0);

    // 2: write-through bypass then commit
    drive(1, 8, 32'h1234_5678, 0, 0, 0, 0, 0, 8, 0, 0);
    check("bypass_w0", rdata[DW-1:0], 32'h1234_5678);
    tick();
    drive_idle(0, 8);
    check("commit_w0", dbg_data, 32'h1234_5678);
    tick();

    // 3: write-write collision, younger port wins
    drive(1, 16, 32'hAAAA_AAAA, 1, 16, 32'h5555_5555, 0, 0, 16, 0, 0);
    check("collide_rd", rdata[DW-1:0], 32'h5555_5555);
    tick();
    drive_idle(0, 16);
    check("collide_st", dbg_data, 32'h5555_5555);
    tick();

    // 4: zero register ignores writes and issues
    drive(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
    check("zero_rd", rdata[DW-1:0], 32'd0);
    tick();
    drive_idle(0, 0);
    check("zero_rd_after", rdata[DW-1:0], 32'd0);
    check("zero_busy", {31'd0, busy_vec[0]}, 32'd0);
    tick();

    // 5: issue timing and writeback release
    drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 0);
    check("iss_rbusy_n", {31'd0, rbusy[0]}, 32'd0);
    tick();
    drive_idle(9, 0);
    check("iss_rbusy_n1", {31'd0, rbusy[0]}, 32'd1);
    tick();
    drive_idle(9, 0); tick();
    drive(1, 9, 32'h99, 0, 0, 0, 0, 0, 9, 0, 0);
    check("wb_rbusy", {31'd0, rbusy[0]}, 32'd0);
    tick();
    drive_idle(9, 9);
    check("wb_busy_clr", {31'd0, busy_vec[9]}, 32'd0);
    tick();

    // 6: issue beats writeback on the same register
    drive(1, 10, 32'h42, 0, 0, 0, 1, 10, 10, 0, 0);
    check("iss_wb_rd", rdata[DW-1:0], 32'h42);
    tick();
    drive_idle(0, 10);
    check("iss_wb_busy", {31'd0, busy_vec[10]}, 32'd1);
    check("iss_wb_st", dbg_data, 32'h42);
    tick();

    // random traffic with occasional resets
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive_random();
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
